uart_tx_param: RTL and testbench

- Parametrised UART transmitter; successor to the fixed 8N1 transmitter.
- Runs on the system clock with an internal per-bit baud divider, so no divided clock is needed.
- Latches the payload on a valid/ready handshake; configurable data width, stop bits and optional parity.
- Sits between the TX buffer (upstream) and the FTDI serial pin (downstream).

---
 rtl/uart_tx_param_pkg.sv | 38 +++
 rtl/uart_baud_tick.sv | 48 ++++
 rtl/uart_tx_param.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_tx_param.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_param_pkg.sv
// -----------------------------------------------------------------------------
// uartUtil : shared types and helpers for the UART blocks.
//
// Contents
//   states_t    - state set of the original fixed 8N1 transmitter, kept so
//                 older code that imports this package still elaborates.
//   tx_state_t  - state set of the parametrised transmitter uart_tx_param.
//   cnt_width() - counter width helper that never returns 0, so a counter
//                 for a range of size 1 is still a legal 1-bit vector.
//
// No ports (package).
// -----------------------------------------------------------------------------
package uartUtil;

  // Original fixed-format transmitter states.
  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } states_t;

  // Parametrised transmitter states. PARITY is only entered when the
  // design is built with UART_TX_PARITY_EN.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Width of a counter that must hold the values 0..n-1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick : per-bit baud divider running on the system clock.
//
// A free-running counter 0..BAUD_DIV-1. bit_end is high (combinationally)
// during the last clock of every bit period, and the counter wraps to 0 on
// that edge. clr restarts the bit period from 0 and wins over wrapping.
// Shared between the transmitter and the future receiver.
//
// Parameters
//   BAUD_DIV  clk cycles per serial bit, >= 2
// Ports
//   clk      in   system clock
//   rst      in   synchronous active-low reset
//   clr      in   restart the bit period (counter to 0 on the next edge)
//   bit_end  out  high during the final clock of a bit period
// -----------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int BAUD_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST_CNT = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    bit_end = (cnt_q == LAST_CNT);
    cnt_d   = cnt_q + CW'(1);
    if (clr || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param : parametrised UART transmitter (successor to the fixed 8N1).
//
// Takes a word from the TX buffer on a valid/ready handshake and serialises
// it LSB first on tx: start bit (0), DATA_BITS data bits, optional parity
// bit, STOP_BITS stop bits (1). Each bit lasts BAUD_DIV system clocks.
// A new word can be accepted on the final clock of the last stop bit, so
// frames can be sent back to back with no idle gap.
//
// Build option
//   UART_TX_PARITY_EN  when defined, a parity bit is inserted after the data
//                      bits (even when PARITY_ODD=0, odd when PARITY_ODD=1).
//                      When undefined, no parity logic exists and
//                      PARITY_ODD has no effect.
//
// Parameters
//   DATA_BITS   payload bits per frame, 5..9
//   STOP_BITS   stop bits per frame, 1 or 2
//   BAUD_DIV    clk cycles per serial bit, >= 2
//   PARITY_ODD  parity sense, 0 = even, 1 = odd
// Ports
//   clk       in   system clock
//   rst       in   synchronous active-low reset
//   tx_valid  in   upstream has a word on tx_data
//   tx_ready  out  a word is accepted on this clock if tx_valid is high
//   tx_data   in   payload (DATA_BITS), sent LSB first
//   tx        out  serial line, idles high (registered)
//   busy      out  a frame is in progress (registered)
//   done      out  one-cycle pulse after the last stop-bit clock (registered)
// -----------------------------------------------------------------------------
module uart_tx_param
  import uartUtil::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int BAUD_DIV   = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  // Refuse to elaborate an out-of-range configuration instead of silently
  // producing a malformed frame.
  if ((DATA_BITS < 5) || (DATA_BITS > 9) ||
      ((STOP_BITS != 1) && (STOP_BITS != 2)) ||
      (BAUD_DIV < 2) ||
      ((PARITY_ODD != 0) && (PARITY_ODD != 1))) begin : g_bad_params
    $error("uart_tx_param: illegal parameter combination");
  end

  localparam int BW = cnt_width(DATA_BITS);
  localparam int SW = cnt_width(STOP_BITS);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [SW-1:0] LAST_STOP = SW'(STOP_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]        stop_cnt_q, stop_cnt_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic ready_c;   // ready before reset gating
  logic clr;       // restart the baud divider
  logic bit_end;

  uart_baud_tick #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_tick (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ready_c    = 1'b0;
    clr        = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        clr     = 1'b1;   // keep the divider parked so START gets a full bit
      end

      START: begin
        if (bit_end) begin
          state_d   = DATA;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
        end
      end

      // shift_q always holds the bits still to be sent, so its LSB is the
      // next data bit to put on the line.
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d    = STOP;
            tx_d       = 1'b1;
            stop_cnt_d = '0;
`endif
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d    = STOP;
          tx_d       = 1'b1;
          stop_cnt_d = '0;
        end
      end
`endif

      STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (stop_cnt_q == LAST_STOP) begin
            // Final clock of the frame: report completion and offer the
            // slot to the next word. An accept below overrides the return
            // to IDLE and starts the next frame on the same edge.
            ready_c = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            stop_cnt_d = stop_cnt_q + SW'(1);
          end
        end
      end

      default: begin
        state_d    = IDLE;
        tx_d       = 1'b1;
        busy_d     = 1'b0;
        shift_d    = '0;
        bit_cnt_d  = '0;
        stop_cnt_d = '0;
      end
    endcase

    if (ready_c && tx_valid) begin
      state_d    = START;
      shift_d    = tx_data;
      tx_d       = 1'b0;
      busy_d     = 1'b1;
      clr        = 1'b1;
      bit_cnt_d  = '0;
      stop_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
      // Parity is fixed from the word as accepted, not from the shifter.
      parity_d   = (^tx_data) ^ (PARITY_ODD != 0);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  // Held low throughout reset, even before the first edge clears the state.
  assign tx_ready = rst & ready_c;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_param : self-checking bench for uart_tx_param.
//
// Two instances: A (8 data, 1 stop, BAUD_DIV=4, even) and B (5 data, 2 stop,
// BAUD_DIV=3, odd). For every frame the bench pushes the expected per-clock
// {tx, busy, done, tx_ready} into a queue; a negedge checker pops and
// compares one entry per clock while the queue is non-empty.
// Honours UART_TX_PARITY_EN in its frame model.
// -----------------------------------------------------------------------------
module tb_uart_tx_param;

  localparam int NB_A = 8, NS_A = 1, BD_A = 4, PO_A = 0;
  localparam int NB_B = 5, NS_B = 2, BD_B = 3, PO_B = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int BIG = 1 << 30;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       va, ra, txa, busya, donea;
  logic [7:0] da;
  logic       vb, rb, txb, busyb, doneb;
  logic [4:0] db;

  uart_tx_param #(
    .DATA_BITS(NB_A), .STOP_BITS(NS_A), .BAUD_DIV(BD_A), .PARITY_ODD(PO_A)
  ) u_dut_a (
    .clk(clk), .rst(rst), .tx_valid(va), .tx_ready(ra), .tx_data(da),
    .tx(txa), .busy(busya), .done(donea)
  );

  uart_tx_param #(
    .DATA_BITS(NB_B), .STOP_BITS(NS_B), .BAUD_DIV(BD_B), .PARITY_ODD(PO_B)
  ) u_dut_b (
    .clk(clk), .rst(rst), .tx_valid(vb), .tx_ready(rb), .tx_data(db),
    .tx(txb), .busy(busyb), .done(doneb)
  );

  int checks = 0;
  int errors = 0;

  // Entries are {tx, busy, done, tx_ready}.
  logic [3:0] exp_a[$];
  logic [3:0] exp_b[$];

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (tx,busy,done,ready)", tag, obs, exp);
    end
  endtask

  function automatic int flen(input int sel);
    if (sel == 0) return BD_A * (1 + NB_A + PAR + NS_A);
    return BD_B * (1 + NB_B + PAR + NS_B);
  endfunction

  function automatic void push_e(input int sel, input logic [3:0] e);
    if (sel == 0) exp_a.push_back(e);
    else          exp_b.push_back(e);
  endfunction

  // Expected line levels for one frame, one entry per clock starting with
  // the clock right after the accept edge; at most 'limit' entries.
  function automatic void push_frame(input int sel, input logic [8:0] data,
                                     input bit first_done, input int limit);
    int nb = (sel == 0) ? NB_A : NB_B;
    int ns = (sel == 0) ? NS_A : NS_B;
    int bd = (sel == 0) ? BD_A : BD_B;
    int po = (sel == 0) ? PO_A : PO_B;
    logic [15:0] bits = '0;
    int n = 0;
    int ones = 0;
    int len;
    bits[n] = 1'b0;
    n++;
    for (int j = 0; j < nb; j++) begin
      bits[n] = data[j];
      n++;
      if (data[j]) ones++;
    end
    if (PAR != 0) begin
      bits[n] = ((ones % 2) == 1) ^ (po != 0);
      n++;
    end
    for (int k = 0; k < ns; k++) begin
      bits[n] = 1'b1;
      n++;
    end
    len = n * bd;
    for (int i = 0; i < len && i < limit; i++) begin
      push_e(sel, {bits[i / bd], 1'b1, (i == 0) && first_done, i == len - 1});
    end
  endfunction

  always @(negedge clk) begin
    if (exp_a.size() > 0) check("dut_a_cycle", {txa, busya, donea, ra}, exp_a.pop_front());
    if (exp_b.size() > 0) check("dut_b_cycle", {txb, busyb, doneb, rb}, exp_b.pop_front());
  end

  // Single frame from idle, followed by the done pulse and one quiet cycle.
  task automatic send(input int sel, input logic [8:0] data);
    @(negedge clk);
    #1;
    if (sel == 0) begin da = data[7:0]; va = 1'b1; end
    else          begin db = data[4:0]; vb = 1'b1; end
    push_frame(sel, data, 1'b0, BIG);
    push_e(sel, 4'b1011);
    push_e(sel, 4'b1001);
    $display("send dut_%s data=0x%0h", (sel == 0) ? "a" : "b", data);
    @(posedge clk);
    #1;
    if (sel == 0) va = 1'b0;
    else          vb = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && (exp_a.size() != 0 || exp_b.size() != 0); i++) @(negedge clk);
    check("drain_timeout", {2'b00, exp_a.size() != 0, exp_b.size() != 0}, 4'b0000);
    exp_a.delete();
    exp_b.delete();
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    va = 1'b0; vb = 1'b0; da = '0; db = '0;

    // Reset values, then idle after release.
    repeat (3) @(negedge clk);
    check("reset_a", {txa, busya, donea, ra}, 4'b1000);
    check("reset_b", {txb, busyb, doneb, rb}, 4'b1000);
    #1 rst = 1'b1;
    @(negedge clk);
    check("idle_a", {txa, busya, donea, ra}, 4'b1001);
    check("idle_b", {txb, busyb, doneb, rb}, 4'b1001);

    // 0xA5, 8N1 at BAUD_DIV=4.
    send(0, 9'h0A5);
    drain();

    // Back to back: valid held high with 0x00 then 0xFF.
    @(negedge clk);
    #1 da = 8'h00; va = 1'b1;
    push_frame(0, 9'h000, 1'b0, BIG);
    push_frame(0, 9'h0FF, 1'b1, BIG);
    push_e(0, 4'b1011);
    push_e(0, 4'b1001);
    $display("send dut_a back-to-back data=0x00,0xff");
    @(posedge clk);
    #1 da = 8'hFF;
    repeat (flen(0)) @(posedge clk);
    #1 va = 1'b0;
    drain();

    // tx_data scrambled every cycle after accepting 0x5A.
    @(negedge clk);
    #1 da = 8'h5A; va = 1'b1;
    push_frame(0, 9'h05A, 1'b0, BIG);
    push_e(0, 4'b1011);
    push_e(0, 4'b1001);
    $display("send dut_a data=0x5a with changing tx_data");
    @(posedge clk);
    #1 va = 1'b0;
    for (int i = 0; i < 200 && exp_a.size() > 0; i++) begin
      @(posedge clk);
      #1 da = 8'($urandom);
    end
    drain();

    // 5 data bits, 2 stop bits.
    send(1, 9'h01F);
    drain();

    // 0x07 on both: parity 1 (even) on A, 0 (odd) on B when parity is built.
    fork
      send(0, 9'h007);
      send(1, 9'h007);
    join
    drain();

    // Reset asserted in the middle of data bit 3.
    @(negedge clk);
    #1 da = 8'h96; va = 1'b1;
    push_frame(0, 9'h096, 1'b0, BD_A * 4 + 2);
    push_e(0, 4'b1000);
    push_e(0, 4'b1000);
    push_e(0, 4'b1001);
    $display("send dut_a data=0x96 with reset during data bit 3");
    @(posedge clk);
    #1 va = 1'b0;
    repeat (BD_A * 4 + 1) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    drain();
    send(0, 9'h03C);
    drain();

    // A few random words on each instance.
    for (int k = 0; k < 3; k++) begin
      send(0, 9'($urandom_range(0, 255)));
      drain();
      send(1, 9'($urandom_range(0, 31)));
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
